// File: rtl/sdram_arb_pkg.sv
// Shared types and widths for the SDRAM requester arbiter.
package sdram_arb_pkg;

   localparam int ADDR_W  = 25;
   localparam int DATA_W  = 32;
   // Widest supported requester count; index width covers ports 0..7.
   localparam int MAX_REQ = 8;
   localparam int IDX_W   = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      BUSY  = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

   // Next round-robin start position: one past the winner, wrapping past port 0.
   function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] win, input int n_req);
      if (win == IDX_W'(n_req - 1)) begin
         return IDX_W'(1);
      end
      return IDX_W'(win + 1'b1);
   endfunction

endpackage

// File: rtl/sdram_rr_pick.sv
// Combinational winner picker: bounded priority for port 0, cyclic scan over ports 1..N_REQ-1.
module sdram_rr_pick
   import sdram_arb_pkg::*;
#(
   parameter int N_REQ  = 3,
   parameter int MAX_P0 = 4,
   parameter int CNT_W  = $clog2(MAX_P0 + 1)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDX_W-1:0] rr_ptr_i,
   input  logic [CNT_W-1:0] p0_cnt_i,
   output logic [IDX_W-1:0] win_o,
   output logic             valid_o
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_P0);
   localparam int               N_RR    = N_REQ - 1;

   logic [MAX_REQ-1:0] req_ext;
   logic               others_pending;
   logic [IDX_W-1:0]   cand_idx [N_RR];
   logic [N_RR-1:0]    cand_hit;

   assign req_ext        = MAX_REQ'(req_i);
   assign others_pending = |req_i[N_REQ-1:1];

   // Candidate gi is the gi-th port visited when scanning from rr_ptr, wrapping N_REQ-1 -> 1.
   genvar gi;
   generate
      for (gi = 0; gi < N_RR; gi++) begin : g_cand
         logic [IDX_W:0] sum;
         assign sum          = {1'b0, rr_ptr_i} + (IDX_W+1)'(gi);
         assign cand_idx[gi] = (sum >= (IDX_W+1)'(N_REQ)) ? IDX_W'(sum - (IDX_W+1)'(N_RR))
                                                          : sum[IDX_W-1:0];
         assign cand_hit[gi] = req_ext[cand_idx[gi]];
      end
   endgenerate

   // Port 0 wins while under its burst budget or when nobody else waits; else first hit in scan order.
   always_comb begin
      logic hit;
      win_o   = '0;
      valid_o = 1'b0;
      hit     = 1'b0;
      if (req_i[0] && ((p0_cnt_i < MAX_CNT) || !others_pending)) begin
         valid_o = 1'b1;
      end else begin
         for (int k = 0; k < N_RR; k++) begin
            if (!hit && cand_hit[k]) begin
               hit   = 1'b1;
               win_o = cand_idx[k];
            end
         end
         valid_o = hit;
      end
   end

endmodule

// File: rtl/sdram_arbiter.sv
// Multiplexes N_REQ single-word requesters onto one SDRAM master port, one transaction at a time.
module sdram_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int N_REQ  = 3,
   parameter int MAX_P0 = 4
) (
   input  logic                    Clk,
   input  logic                    Reset_n,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ-1:0]        we,
   input  logic [N_REQ*ADDR_W-1:0] addr,
   input  logic [N_REQ*DATA_W-1:0] wdata,
   output logic [N_REQ-1:0]        ack,
   output logic [DATA_W-1:0]       rdata,
   output logic                    mem_read_req,
   output logic                    mem_write_req,
   output logic [ADDR_W-1:0]       mem_address,
   output logic [DATA_W-1:0]       mem_write_data,
   input  logic                    mem_ready,
   input  logic [DATA_W-1:0]       mem_rdata
);

   localparam int               CNT_W   = $clog2(MAX_P0 + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_P0);

   arb_state_t        state_q, state_d;
   logic [IDX_W-1:0]  win_q, win_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [N_REQ-1:0]  ack_q, ack_d;
   logic [CNT_W-1:0]  p0_cnt_q, p0_cnt_d;
   logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;

   logic [IDX_W-1:0]  pick_win;
   logic              pick_valid;
   logic              others_pending;

   logic [MAX_REQ-1:0] we_ext;
   logic [ADDR_W-1:0]  addr_a  [MAX_REQ];
   logic [DATA_W-1:0]  wdata_a [MAX_REQ];

   assign we_ext         = MAX_REQ'(we);
   assign others_pending = |req[N_REQ-1:1];

   // Unpack the flat per-port buses so the winner can be selected by index; unused slots read 0.
   genvar gi;
   generate
      for (gi = 0; gi < MAX_REQ; gi++) begin : g_unpack
         if (gi < N_REQ) begin : g_used
            assign addr_a[gi]  = addr[gi*ADDR_W +: ADDR_W];
            assign wdata_a[gi] = wdata[gi*DATA_W +: DATA_W];
         end else begin : g_unused
            assign addr_a[gi]  = '0;
            assign wdata_a[gi] = '0;
         end
      end
   endgenerate

   sdram_rr_pick #(
      .N_REQ  (N_REQ),
      .MAX_P0 (MAX_P0),
      .CNT_W  (CNT_W)
   ) u_pick (
      .req_i    (req),
      .rr_ptr_i (rr_ptr_q),
      .p0_cnt_i (p0_cnt_q),
      .win_o    (pick_win),
      .valid_o  (pick_valid)
   );

   // Next-state decode: latch winner in IDLE, strobe in ISSUE, wait in BUSY, acknowledge in DONE.
   always_comb begin
      state_d  = state_q;
      win_d    = win_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      ack_d    = '0;
      p0_cnt_d = p0_cnt_q;
      rr_ptr_d = rr_ptr_q;
      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               win_d   = pick_win;
               we_d    = we_ext[pick_win];
               addr_d  = addr_a[pick_win];
               wdata_d = wdata_a[pick_win];
               state_d = ISSUE;
               if (pick_win == '0) begin
                  if (others_pending && (p0_cnt_q < MAX_CNT)) begin
                     p0_cnt_d = p0_cnt_q + 1'b1;
                  end
               end else begin
                  p0_cnt_d = '0;
                  rr_ptr_d = rr_next(pick_win, N_REQ);
               end
            end
         end
         ISSUE: begin
            state_d = BUSY;
         end
         BUSY: begin
            if (mem_ready) begin
               if (!we_q) begin
                  rdata_d = mem_rdata;
               end
               for (int i = 0; i < N_REQ; i++) begin
                  ack_d[i] = (win_q == IDX_W'(i));
               end
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q  <= IDLE;
         win_q    <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         ack_q    <= '0;
         p0_cnt_q <= '0;
         rr_ptr_q <= IDX_W'(1);
      end else begin
         state_q  <= state_d;
         win_q    <= win_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         ack_q    <= ack_d;
         p0_cnt_q <= p0_cnt_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // Strobes are the only decoded outputs; address and data stay on their latches all transaction.
   assign mem_read_req   = (state_q == ISSUE) && !we_q;
   assign mem_write_req  = (state_q == ISSUE) &&  we_q;
   assign mem_address    = addr_q;
   assign mem_write_data = wdata_q;
   assign ack            = ack_q;
   assign rdata          = rdata_q;

endmodule
